write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, at least 2).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  the single clock, rising-edge active.
REQ-005 reset  input  1  reset is asynchronous and active-low.
REQ-006 wr_valid  input  1  store request from the cache write path.
REQ-007 wr_ready  output  1  buffer can accept a store this cycle.
REQ-008 wr_addr  input  AW  store byte address; entries match on wr_addr[AW-1:2].
REQ-009 wr_data  input  DW  store data.
REQ-010 mem_req  output  1  drain request to data memory.
REQ-011 mem_ack  input  1  data memory accepted the head entry.
REQ-012 mem_addr  output  AW  head entry address.
REQ-013 mem_wdata  output  DW  head entry data.
REQ-014 rd_addr  input  AW  load address for forwarding lookup.
REQ-015 rd_hit  output  1  a buffered entry matches rd_addr.
REQ-016 rd_data  output  DW  data of the youngest matching entry.
REQ-017 flush  input  1  level request to drain the buffer.
REQ-018 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-019 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-020 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-021 The buffer SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-022 wr_ready SHALL equal !full && !flush_active, decoded from registered state only.
REQ-023 A store is accepted on a rising edge with wr_valid && wr_ready; the accepted entry is visible one cycle later.
REQ-024 Merge: if the accepted store word-matches a valid non-head entry, that entry's data is overwritten and count is unchanged; otherwise a new tail entry is allocated.
REQ-025 A store matching only the head entry SHALL allocate a new entry, never merge.
REQ-026 The drain FSM has two states, IDLE and BUSY.
- IDLE goes to BUSY when !empty.
- BUSY returns to IDLE on mem_ack when count becomes 0; otherwise it stays in BUSY.
REQ-027 mem_req SHALL be high exactly in BUSY, with mem_addr and mem_wdata held stable until mem_ack is sampled high.
REQ-028 mem_ack sampled high in BUSY dequeues the head entry on that edge; mem_ack in IDLE SHALL be ignored.
REQ-029 On the same edge, an enqueue and a dequeue SHALL leave count unchanged and move both pointers.
REQ-030 Merge into an entry and dequeue of the head may coincide; both SHALL take effect.
REQ-031 rd_hit and rd_data SHALL be combinational over the valid entries, with the youngest match taking priority; when rd_hit=0, rd_data SHALL be 0.
REQ-032 A store being accepted in the same cycle SHALL NOT be forwarded.
REQ-033 Flush: flush_active sets when flush is sampled high; it clears, pulsing flush_done for one cycle, on the first edge where count==0.
REQ-034 A flush with the buffer already empty SHALL pulse flush_done on the next edge.
REQ-035 Drain latency SHALL be unbounded, with mem_req held indefinitely until mem_ack.

Reset
REQ-036 When reset is low, the block SHALL immediately (asynchronously) set the FSM to IDLE, both pointers to 0, count to 0, all valid bits to 0, and flush_active to 0.
REQ-037 During reset, outputs SHALL be: mem_req=0, mem_addr=0, mem_wdata=0, rd_hit=0, rd_data=0, flush_done=0, full=0, empty=1.
REQ-038 wr_ready SHALL be 0 while reset is low and 1 on the first cycle after release.
REQ-039 Reset asserted during BUSY SHALL discard all entries and drop mem_req in the same cycle, without waiting for a clock edge.

Verification
REQ-040 Single store: store addr=0x10, data=0xA5 with mem_ack tied 0 -> count=1 and mem_req=1 with mem_addr=0x10 held; assert mem_ack for 1 cycle -> count=0, IDLE.
REQ-041 Fill: 4 distinct stores with mem_ack=0 -> full=1, wr_ready=0, and a 5th store is not accepted; 1 ack -> wr_ready=1 the next cycle.
REQ-042 Merge and forward: stores to 0x20 (data 1), 0x24 (data 2), 0x24 (data 3) -> count=2; rd_addr=0x24 -> rd_hit=1, rd_data=3; rd_addr=0x26 -> rd_data=3.
REQ-043 Head no-merge: store to 0x40 with mem_req pending, then store to 0x40 with data 9 -> count=2 and forwarding returns 9; after two acks memory sees the old data, then 9.
REQ-044 Simultaneous events: count=2, and an enqueue and an mem_ack land on the same edge -> count=2 and the pointers wrap correctly past DEPTH-1.
REQ-045 Flush and reset: flush with 3 entries -> wr_ready=0 until empty, then a single flush_done pulse; reset low mid-BUSY -> mem_req=0 with no clock edge and count=0.

Source files
------------

// File: rtl/write_buffer_if.sv
// Store-buffer bus bundle: cache write path, drain-to-memory port,
// load-forwarding lookup and flush/status signals.
interface write_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;
  logic [DW-1:0] rd_data;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_ack, rd_addr, flush,
    output wr_ready, mem_req, mem_addr, mem_wdata, rd_hit, rd_data,
           flush_done, count, full, empty
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_ack, rd_addr, flush,
    input  wr_ready, mem_req, mem_addr, mem_wdata, rd_hit, rd_data,
           flush_done, count, full, empty
  );
endinterface

// File: rtl/write_buffer.sv
// Circular store buffer with word-granular merging, youngest-match load
// forwarding, a two-state drain FSM toward data memory, and flush support.
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic clk,
  input  logic reset,
  write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic                     flush_active, flush_done_q;

  logic          full, empty, enq, deq, alloc, merge;
  logic          merge_hit;
  logic [PW-1:0] merge_idx;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] fwd_idx;
  logic          unused_rd_lsb;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Gating with reset keeps wr_ready low while held in reset yet high on
  // the very first cycle after release.
  assign bus.wr_ready = reset && !full && !flush_active;

  assign enq     = bus.wr_valid && bus.wr_ready;
  assign deq     = (state == BUSY) && bus.mem_ack;
  assign alloc   = enq && !merge_hit;
  assign merge   = enq && merge_hit;
  assign cnt_nxt = cnt + CW'(alloc) - CW'(deq);

  // The head may already be on the memory bus, so it never takes a merge.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (PW'(i) != head) &&
          (ent_addr[i][AW-1:2] == bus.wr_addr[AW-1:2])) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (vld[fwd_idx] && (ent_addr[fwd_idx][AW-1:2] == bus.rd_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[fwd_idx];
      end
    end
  end

  assign unused_rd_lsb = ^bus.rd_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      vld          <= '0;
      ent_addr     <= '0;
      ent_data     <= '0;
      flush_active <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (alloc) begin
        ent_addr[tail] <= bus.wr_addr;
        ent_data[tail] <= bus.wr_data;
        vld[tail]      <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (merge)
        ent_data[merge_idx] <= bus.wr_data;
      cnt <= cnt_nxt;

      case (state)
        IDLE: if (!empty) state <= BUSY;
        BUSY: if (deq && (cnt_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase

      flush_done_q <= 1'b0;
      if (flush_active && empty) begin
        flush_active <= 1'b0;
        flush_done_q <= 1'b1;
      end else if (bus.flush) begin
        flush_active <= 1'b1;
      end
    end
  end

  assign bus.mem_req    = (state == BUSY);
  assign bus.mem_addr   = (state == BUSY) ? ent_addr[head] : '0;
  assign bus.mem_wdata  = (state == BUSY) ? ent_data[head] : '0;
  assign bus.rd_hit     = fwd_hit;
  assign bus.rd_data    = fwd_data;
  assign bus.flush_done = flush_done_q;
  assign bus.count      = cnt;
  assign bus.full       = full;
  assign bus.empty      = empty;
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: store, fill, merge/forward, head rules,
// concurrent enqueue/dequeue with wrap, flush and asynchronous reset.
module tb_write_buffer;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  write_buffer_if #(.AW(32), .DW(32), .CW(3)) bus ();

  write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic ack();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.mem_ack = 0; bus.rd_addr = 0; bus.flush = 0;
    #12;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); end
    tests++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
    tests++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'h0) begin fails++; $display("FAIL rst_fwd got %b/%h exp 0/0", bus.rd_hit, bus.rd_data); end
    tests++; if (bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.flush_done !== 1'b0) begin fails++; $display("FAIL rst_status full=%b empty=%b fd=%b exp 0/1/0", bus.full, bus.empty, bus.flush_done); end
    tests++; if (bus.wr_ready !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL rst_ready rdy=%b cnt=%0d exp 0/0", bus.wr_ready, bus.count); end
    @(negedge clk) reset = 1'b1;
    #1;
    tests++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", bus.wr_ready); end
  endtask

  task automatic test_single();
    put(32'h10, 32'hA5);
    tests++; if (bus.count !== 3'd1 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL single_accept cnt=%0d req=%b exp 1/0", bus.count, bus.mem_req); end
    step();
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hA5) begin fails++; $display("FAIL single_req req=%b addr=%h data=%h exp 1/10/a5", bus.mem_req, bus.mem_addr, bus.mem_wdata); end
    step(); step();
    tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.count !== 3'd1) begin fails++; $display("FAIL single_hold req=%b addr=%h cnt=%0d exp 1/10/1", bus.mem_req, bus.mem_addr, bus.count); end
    ack();
    tests++; if (bus.count !== 3'd0 || bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL single_drain cnt=%0d req=%b empty=%b exp 0/0/1", bus.count, bus.mem_req, bus.empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(4*i), 32'h1000 + 32'(i));
    tests++; if (bus.full !== 1'b1 || bus.wr_ready !== 1'b0 || bus.count !== 3'd4) begin fails++; $display("FAIL fill_full full=%b rdy=%b cnt=%0d exp 1/0/4", bus.full, bus.wr_ready, bus.count); end
    put(32'h110, 32'hDEAD);
    tests++; if (bus.count !== 3'd4 || bus.mem_addr !== 32'h100) begin fails++; $display("FAIL fill_reject cnt=%0d addr=%h exp 4/100", bus.count, bus.mem_addr); end
    ack();
    tests++; if (bus.wr_ready !== 1'b1 || bus.count !== 3'd3) begin fails++; $display("FAIL fill_ack rdy=%b cnt=%0d exp 1/3", bus.wr_ready, bus.count); end
    for (int i = 1; i < 4; i++) begin
      tests++; if (bus.mem_addr !== 32'h100 + 32'(4*i)) begin fails++; $display("FAIL fill_order%0d got %h exp %h", i, bus.mem_addr, 32'h100 + 32'(4*i)); end
      ack();
    end
    tests++; if (bus.count !== 3'd0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL fill_empty cnt=%0d req=%b exp 0/0", bus.count, bus.mem_req); end
  endtask

  task automatic test_merge();
    put(32'h20, 32'd1);
    put(32'h24, 32'd2);
    put(32'h24, 32'd3);
    tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL merge_count got %0d exp 2", bus.count); end
    bus.rd_addr = 32'h24; #1;
    tests++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'd3) begin fails++; $display("FAIL merge_fwd24 hit=%b data=%0d exp 1/3", bus.rd_hit, bus.rd_data); end
    bus.rd_addr = 32'h26; #1;
    tests++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'd3) begin fails++; $display("FAIL merge_fwd26 hit=%b data=%0d exp 1/3", bus.rd_hit, bus.rd_data); end
    bus.rd_addr = 32'h20; #1;
    tests++; if (bus.rd_data !== 32'd1) begin fails++; $display("FAIL merge_fwd20 got %0d exp 1", bus.rd_data); end
    bus.rd_addr = 32'h30; #1;
    tests++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'd0) begin fails++; $display("FAIL merge_miss hit=%b data=%0d exp 0/0", bus.rd_hit, bus.rd_data); end
    // merge into 0x24 on the same edge the head drains
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h24; bus.wr_data = 32'd7; bus.mem_ack = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.mem_ack = 1'b0;
    tests++; if (bus.count !== 3'd1 || bus.mem_addr !== 32'h24 || bus.mem_wdata !== 32'd7) begin fails++; $display("FAIL merge_deq cnt=%0d addr=%h data=%0d exp 1/24/7", bus.count, bus.mem_addr, bus.mem_wdata); end
    ack();
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL merge_drain got %0d exp 0", bus.count); end
  endtask

  task automatic test_head_nomerge();
    put(32'h40, 32'd8);
    step();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL head_req got %b exp 1", bus.mem_req); end
    put(32'h40, 32'd9);
    bus.rd_addr = 32'h40; #1;
    tests++; if (bus.count !== 3'd2 || bus.rd_data !== 32'd9) begin fails++; $display("FAIL head_alloc cnt=%0d fwd=%0d exp 2/9", bus.count, bus.rd_data); end
    tests++; if (bus.mem_wdata !== 32'd8) begin fails++; $display("FAIL head_old got %0d exp 8", bus.mem_wdata); end
    ack();
    tests++; if (bus.mem_wdata !== 32'd9 || bus.mem_addr !== 32'h40) begin fails++; $display("FAIL head_new data=%0d addr=%h exp 9/40", bus.mem_wdata, bus.mem_addr); end
    ack();
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL head_drain got %0d exp 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    put(32'h50, 32'h11);
    put(32'h54, 32'h22);
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h58 + 32'(4*i); bus.wr_data = 32'h33 + 32'(17*i);
      bus.mem_ack = 1'b1;
      step();
      bus.wr_valid = 1'b0; bus.mem_ack = 1'b0;
      tests++; if (bus.count !== 3'd2 || bus.mem_addr !== 32'h54 + 32'(4*i)) begin fails++; $display("FAIL b2b_%0d cnt=%0d addr=%h exp 2/%h", i, bus.count, bus.mem_addr, 32'h54 + 32'(4*i)); end
    end
    bus.rd_addr = 32'h60; #1;
    tests++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 32'h55) begin fails++; $display("FAIL b2b_fwd hit=%b data=%h exp 1/55", bus.rd_hit, bus.rd_data); end
    bus.rd_addr = 32'h58; #1;
    tests++; if (bus.rd_hit !== 1'b0) begin fails++; $display("FAIL b2b_gone got %b exp 0", bus.rd_hit); end
    ack();
    tests++; if (bus.mem_addr !== 32'h60 || bus.mem_wdata !== 32'h55) begin fails++; $display("FAIL b2b_wrap addr=%h data=%h exp 60/55", bus.mem_addr, bus.mem_wdata); end
    ack();
    tests++; if (bus.count !== 3'd0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL b2b_drain cnt=%0d req=%b exp 0/0", bus.count, bus.mem_req); end
  endtask

  task automatic test_flush();
    put(32'h70, 32'd1); put(32'h74, 32'd2); put(32'h78, 32'd3);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL flush_block got %b exp 0", bus.wr_ready); end
    put(32'h7C, 32'd4);
    tests++; if (bus.count !== 3'd3) begin fails++; $display("FAIL flush_reject got %0d exp 3", bus.count); end
    ack(); ack(); ack();
    tests++; if (bus.count !== 3'd0 || bus.wr_ready !== 1'b0 || bus.flush_done !== 1'b0) begin fails++; $display("FAIL flush_drained cnt=%0d rdy=%b fd=%b exp 0/0/0", bus.count, bus.wr_ready, bus.flush_done); end
    step();
    tests++; if (bus.flush_done !== 1'b1 || bus.wr_ready !== 1'b1) begin fails++; $display("FAIL flush_pulse fd=%b rdy=%b exp 1/1", bus.flush_done, bus.wr_ready); end
    step();
    tests++; if (bus.flush_done !== 1'b0) begin fails++; $display("FAIL flush_single got %b exp 0", bus.flush_done); end
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    tests++; if (bus.flush_done !== 1'b0 || bus.wr_ready !== 1'b0) begin fails++; $display("FAIL flush_empty_set fd=%b rdy=%b exp 0/0", bus.flush_done, bus.wr_ready); end
    step();
    tests++; if (bus.flush_done !== 1'b1) begin fails++; $display("FAIL flush_empty_pulse got %b exp 1", bus.flush_done); end
    step();
  endtask

  task automatic test_reset_busy();
    put(32'h80, 32'hBEEF);
    step();
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rbusy_req got %b exp 1", bus.mem_req); end
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rbusy_async req=%b cnt=%0d addr=%h exp 0/0/0", bus.mem_req, bus.count, bus.mem_addr); end
    tests++; if (bus.wr_ready !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL rbusy_status rdy=%b empty=%b exp 0/1", bus.wr_ready, bus.empty); end
    @(negedge clk) reset = 1'b1;
    step();
    tests++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0) begin fails++; $display("FAIL rbusy_after req=%b cnt=%0d exp 0/0", bus.mem_req, bus.count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_merge();
    test_head_nomerge();
    test_back_to_back();
    test_flush();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
